// File: rtl/countdown_timer.sv
// HH:MM:SS down-counter with borrow cascade, pause/resume and a one-cycle expiry pulse.
// Optional post-expiry alarm output is built only when COUNTDOWN_ALARM_EN is defined.
module countdown_timer #(
  parameter int HOURS_MAX   = 24,
  parameter int ALARM_TICKS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] sec_in,
  input  logic [7:0] min_in,
  input  logic [7:0] hr_in,
  input  logic       start,
  input  logic       stop,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic [7:0] hr,
  output logic       running,
  output logic       zero,
  output logic       done,
  output logic [1:0] state,
  output logic       alarm
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] SEC_TOP = 8'd59;
  localparam logic [7:0] MIN_TOP = 8'd59;
  localparam logic [7:0] HR_TOP  = 8'(HOURS_MAX - 1);

  // The alarm counter saturates at 255, so larger values would never release the alarm.
  if (ALARM_TICKS > 255) begin : g_alarm_ticks_range
    $error("countdown_timer: ALARM_TICKS must not exceed 255");
  end

  state_t     state_reg;
  logic [7:0] sec_reg;
  logic [7:0] min_reg;
  logic [7:0] hr_reg;
  logic       running_reg;
  logic       zero_reg;
  logic       done_reg;

  // Field order in the packed arrays: 0 = seconds, 1 = minutes, 2 = hours.
  logic [2:0][7:0] preset_raw;
  logic [2:0][7:0] preset_top;
  logic [2:0][7:0] preset_sat;

  assign preset_raw = {hr_in, min_in, sec_in};
  assign preset_top = {HR_TOP, MIN_TOP, SEC_TOP};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sat
    assign preset_sat[gi] = (preset_raw[gi] > preset_top[gi]) ? preset_top[gi] : preset_raw[gi];
  end

  logic [7:0] sec_dec;
  logic [7:0] min_dec;
  logic [7:0] hr_dec;
  logic       dec_hits_zero;

  always_comb begin
    sec_dec = sec_reg - 8'd1;
    min_dec = min_reg;
    hr_dec  = hr_reg;
    if (sec_reg == 8'd0) begin
      sec_dec = SEC_TOP;
      if (min_reg == 8'd0) begin
        min_dec = MIN_TOP;
        hr_dec  = hr_reg - 8'd1;
      end else begin
        min_dec = min_reg - 8'd1;
      end
    end
  end

  // Only 00:00:01 can land on zero; the RUN guard below keeps the count from wrapping.
  assign dec_hits_zero = (hr_reg == 8'd0) && (min_reg == 8'd0) && (sec_reg == 8'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      sec_reg     <= 8'd0;
      min_reg     <= 8'd0;
      hr_reg      <= 8'd0;
      running_reg <= 1'b0;
      zero_reg    <= 1'b1;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (load) begin
        sec_reg     <= preset_sat[0];
        min_reg     <= preset_sat[1];
        hr_reg      <= preset_sat[2];
        zero_reg    <= (preset_sat == '0);
        state_reg   <= IDLE;
        running_reg <= 1'b0;
      end else if (stop) begin
        state_reg   <= (state_reg == RUN) ? PAUSE : IDLE;
        running_reg <= 1'b0;
      end else if (start) begin
        if ((state_reg == IDLE && !zero_reg) || state_reg == PAUSE) begin
          state_reg   <= RUN;
          running_reg <= 1'b1;
        end
      end else if (tick && state_reg == RUN && !zero_reg) begin
        sec_reg <= sec_dec;
        min_reg <= min_dec;
        hr_reg  <= hr_dec;
        if (dec_hits_zero) begin
          zero_reg    <= 1'b1;
          done_reg    <= 1'b1;
          state_reg   <= DONE;
          running_reg <= 1'b0;
        end
      end
    end
  end

  assign sec     = sec_reg;
  assign min     = min_reg;
  assign hr      = hr_reg;
  assign running = running_reg;
  assign zero    = zero_reg;
  assign done    = done_reg;
  assign state   = state_reg;

`ifdef COUNTDOWN_ALARM_EN
  logic       expire_now;
  logic       alarm_reg;
  logic [7:0] alarm_cnt_reg;
  logic [7:0] alarm_cnt_inc;

  assign expire_now    = !load && !stop && !start && tick && (state_reg == RUN) && dec_hits_zero;
  assign alarm_cnt_inc = (alarm_cnt_reg == 8'hFF) ? 8'hFF : alarm_cnt_reg + 8'd1;

  // Ticks swallowed by a coincident start are not counted, matching the tick-discard rule.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_reg     <= 1'b0;
      alarm_cnt_reg <= 8'd0;
    end else if (load || stop) begin
      alarm_reg     <= 1'b0;
      alarm_cnt_reg <= 8'd0;
    end else if (expire_now) begin
      alarm_reg     <= 1'b1;
      alarm_cnt_reg <= 8'd0;
    end else if (!start && tick && state_reg == DONE && alarm_reg) begin
      alarm_cnt_reg <= alarm_cnt_inc;
      if (int'({24'd0, alarm_cnt_inc}) >= ALARM_TICKS) begin
        alarm_reg <= 1'b0;
      end
    end
  end

  assign alarm = alarm_reg;
`else
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random traffic, checked every cycle
// against a remaining-seconds model. Define COUNTDOWN_ALARM_EN to exercise the alarm.
module tb_countdown_timer;
  localparam int HM = 24;
  localparam int AT = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       load = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] sec_in = 8'd0;
  logic [7:0] min_in = 8'd0;
  logic [7:0] hr_in = 8'd0;
  logic [7:0] sec, min, hr;
  logic       running, zero, done, alarm;
  logic [1:0] state;

  countdown_timer #(.HOURS_MAX(HM), .ALARM_TICKS(AT)) dut (
    .clk(clk), .reset(reset), .tick(tick), .load(load),
    .sec_in(sec_in), .min_in(min_in), .hr_in(hr_in),
    .start(start), .stop(stop),
    .sec(sec), .min(min), .hr(hr),
    .running(running), .zero(zero), .done(done),
    .state(state), .alarm(alarm)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: the count is one integer of remaining seconds; fields are derived by division.
  int m_remain = 0;
  int m_state = 0;
  bit m_done = 1'b0;
  bit m_alarm = 1'b0;
  int m_alarm_left = 0;

  function automatic int sat(int v, int top);
    return (v > top) ? top : v;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_remain = 0; m_state = 0; m_done = 1'b0; m_alarm = 1'b0; m_alarm_left = 0;
    end else begin
      m_done = 1'b0;
      if (load) begin
        m_remain = sat(int'(hr_in), HM - 1) * 3600 + sat(int'(min_in), 59) * 60 + sat(int'(sec_in), 59);
        m_state = 0;
        m_alarm = 1'b0;
      end else if (stop) begin
        m_state = (m_state == 1) ? 2 : 0;
        m_alarm = 1'b0;
      end else if (start) begin
        if ((m_state == 0 && m_remain != 0) || m_state == 2) m_state = 1;
      end else if (tick) begin
        if (m_state == 1 && m_remain > 0) begin
          m_remain = m_remain - 1;
          if (m_remain == 0) begin
            m_done = 1'b1;
            m_state = 3;
`ifdef COUNTDOWN_ALARM_EN
            m_alarm = 1'b1;
            m_alarm_left = AT;
`endif
          end
        end else if (m_state == 3 && m_alarm) begin
          m_alarm_left = m_alarm_left - 1;
          if (m_alarm_left <= 0) m_alarm = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cyc_sec", {24'd0, sec}, m_remain % 60);
    check("cyc_min", {24'd0, min}, (m_remain / 60) % 60);
    check("cyc_hr", {24'd0, hr}, m_remain / 3600);
    check("cyc_state", {30'd0, state}, m_state);
    check("cyc_running", {31'd0, running}, int'(m_state == 1));
    check("cyc_zero", {31'd0, zero}, int'(m_remain == 0));
    check("cyc_done", {31'd0, done}, int'(m_done));
    check("cyc_alarm", {31'd0, alarm}, int'(m_alarm));
  end

  // Hand-computed literals pin both the DUT and the model.
  task automatic expect_count(input string tag, input int h, input int m, input int s);
    check({tag, "_hr"}, {24'd0, hr}, h);
    check({tag, "_min"}, {24'd0, min}, m);
    check({tag, "_sec"}, {24'd0, sec}, s);
    check({tag, "_model"}, m_remain, h * 3600 + m * 60 + s);
  endtask

  task automatic expect_ctl(input string tag, input int st, input int dn, input int zr);
    check({tag, "_state"}, {30'd0, state}, st);
    check({tag, "_done"}, {31'd0, done}, dn);
    check({tag, "_zero"}, {31'd0, zero}, zr);
    check({tag, "_mstate"}, m_state, st);
  endtask

  task automatic drive(input bit l, input bit st, input bit sp, input bit tk,
                       input int h, input int m, input int s);
    @(negedge clk);
    load = l; start = st; stop = sp; tick = tk;
    hr_in = 8'(h); min_in = 8'(m); sec_in = 8'(s);
    @(posedge clk);
    #1;
    load = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
  endtask

  task automatic do_load(input int h, input int m, input int s);
    $display("load %0d:%0d:%0d", h, m, s);
    drive(1, 0, 0, 0, h, m, s);
  endtask
  task automatic do_start(); $display("start"); drive(0, 1, 0, 0, 0, 0, 0); endtask
  task automatic do_stop();  $display("stop");  drive(0, 0, 1, 0, 0, 0, 0); endtask
  task automatic do_tick();  drive(0, 0, 0, 1, 0, 0, 0); endtask
  task automatic do_idle();  drive(0, 0, 0, 0, 0, 0, 0); endtask

  initial begin
    #12;
    expect_count("rst", 0, 0, 0);
    expect_ctl("rst", 0, 0, 1);
    check("rst_alarm", {31'd0, alarm}, 0);
    @(negedge clk);
    reset = 1'b1;

    do_load(0, 1, 0);
    expect_count("ld1", 0, 1, 0);
    expect_ctl("ld1", 0, 0, 0);
    do_start();
    check("st1_running", {31'd0, running}, 1);
    $display("tick x1");
    do_tick();
    expect_count("t1", 0, 0, 59);
    $display("tick x58");
    for (int i = 0; i < 58; i++) begin
      do_tick();
      do_idle();
    end
    expect_count("t59", 0, 0, 1);
    $display("tick to expiry");
    do_tick();
    expect_count("exp", 0, 0, 0);
    expect_ctl("exp", 3, 1, 1);
`ifdef COUNTDOWN_ALARM_EN
    check("exp_alarm", {31'd0, alarm}, 1);
`endif
    do_idle();
    expect_ctl("exp_next", 3, 0, 1);
    $display("ticks in done");
    do_tick();
    do_tick();
`ifdef COUNTDOWN_ALARM_EN
    check("alarm_after2", {31'd0, alarm}, 1);
`endif
    do_tick();
    check("alarm_after3", {31'd0, alarm}, 0);

    do_load(2, 0, 0);
    do_start();
    $display("tick double borrow");
    do_tick();
    expect_count("borrow", 1, 59, 59);
    do_load(30, 80, 75);
    expect_count("satur", 23, 59, 59);

    do_start();
    do_stop();
    expect_ctl("pause", 2, 0, 0);
    $display("tick x5 in pause");
    repeat (5) do_tick();
    expect_count("pause_hold", 23, 59, 59);
    do_start();
    check("resume_state", {30'd0, state}, 1);
    do_tick();
    expect_count("resume", 23, 59, 58);
    $display("start+stop");
    drive(0, 1, 1, 0, 0, 0, 0);
    check("ss_state", {30'd0, state}, 2);
    do_stop();
    expect_ctl("to_idle", 0, 0, 0);
    do_tick();
    expect_count("idle_tick", 23, 59, 58);

    do_load(0, 0, 0);
    do_start();
    expect_ctl("zero_start", 0, 0, 1);
    $display("load+tick 0:0:5");
    drive(1, 0, 0, 1, 0, 0, 5);
    expect_count("ld_tick", 0, 0, 5);
    $display("start+tick");
    drive(0, 1, 0, 1, 0, 0, 0);
    expect_count("st_tick", 0, 0, 5);
    check("st_tick_state", {30'd0, state}, 1);

    do_load(0, 0, 1);
    do_start();
    do_tick();
    expect_ctl("exp2", 3, 1, 1);
`ifdef COUNTDOWN_ALARM_EN
    check("exp2_alarm", {31'd0, alarm}, 1);
`endif
    do_stop();
    check("stop_alarm", {31'd0, alarm}, 0);
    expect_ctl("stop_done", 0, 0, 1);

    do_load(1, 2, 3);
    do_start();
    $display("async reset mid-run");
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    expect_count("arst", 0, 0, 0);
    expect_ctl("arst", 0, 0, 1);
    check("arst_alarm", {31'd0, alarm}, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 500; i++) begin
      bit l, st, sp, tk;
      int h, m, s;
      l  = ($urandom_range(0, 99) < 3);
      sp = ($urandom_range(0, 99) < 4);
      st = ($urandom_range(0, 99) < 8);
      tk = ($urandom_range(0, 1) == 1);
      h  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : 0;
      m  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : 0;
      s  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 20));
      if (l || st || sp)
        $display("rnd %0d: load=%0b start=%0b stop=%0b tick=%0b preset=%0d:%0d:%0d", i, l, st, sp, tk, h, m, s);
      drive(l, st, sp, tk, h, m, s);
    end

    do_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable HH:MM:SS countdown timer for the digital clock's timer mode. It is the down-counting counterpart of the clock's mod-N up-counter chain. Seconds, minutes and hours are cascaded down-counters that propagate a borrow instead of a carry. The block is advanced by the shared 1 Hz enable, stops at 00:00:00, and pulses `done`. It sits beside the timekeeping counters and feeds the display mux and the buzzer driver.

## Interface
- `HOURS_MAX`, 24: hours field range is 0..HOURS_MAX-1.
- `ALARM_TICKS`, 10: number of `tick` pulses `alarm` stays high after expiry (only with the macro).

- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `tick`  in  1  1 Hz enable, one `clk` cycle wide.
- `load`  in  1  capture `sec_in`/`min_in`/`hr_in`.
- `sec_in`  in  8  preset seconds, binary.
- `min_in`  in  8  preset minutes, binary.
- `hr_in`  in  8  preset hours, binary.
- `start`  in  1  begin or resume countdown.
- `stop`  in  1  pause, or return to idle.
- `sec`  out  8  remaining seconds 0..59, registered.
- `min`  out  8  remaining minutes 0..59, registered.
- `hr`  out  8  remaining hours 0..HOURS_MAX-1, registered.
- `running`  out  1  high while in RUN.
- `zero`  out  1  registered; high when sec=min=hr=0.
- `done`  out  1  one-cycle pulse on expiry.
- `state`  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.
- `alarm`  out  1  expiry indicator; see Configuration.

## Operation
- State on reset: IDLE. All outputs are 0, except `zero`=1.
- Input priority each cycle: `load` > `stop` > `start` > `tick`.
- `load` (any state):
  - Captures the presets. Each value saturates to its field maximum: sec_in>59→59, min_in>59→59, hr_in≥HOURS_MAX→HOURS_MAX-1.
  - State → IDLE. Clears `alarm`.
- IDLE:
  - `start` with count≠0 → RUN.
  - `start` with count=0 → stay IDLE; no `done`.
  - `tick` is ignored.
- RUN:
  - `stop` → PAUSE. Count is held.
  - `tick` decrements the count:
    - sec≠0: sec−1.
    - sec=0: sec←59 and borrow into min.
    - min=0 under borrow: min←59 and borrow into hr.
    - hr decrements only under borrow.
  - A tick that makes the count 00:00:00: `done`=1 for that one cycle, state → DONE.
  - The count never wraps below zero.
- PAUSE: `start` → RUN; `stop` → IDLE (count kept); `tick` ignored.
- DONE: count is 0. `stop` → IDLE. `start` is ignored. `load` behaves as above.
- Simultaneous `start`+`stop`: `stop` wins.
- `tick` in the same cycle as `load`/`start`/`stop`: the tick is discarded.

## Timing
- `tick` sampled high at edge k → new count is visible after edge k.
- `done` and `zero` assert in the same cycle as the 00:00:00 count.
- State transitions take effect one edge after the request is sampled.
- `running` equals (state==RUN), registered alongside `state`.
- `reset` asserted mid-count clears everything immediately, independent of `clk`. Deassertion is synchronised outside this block.

## Configuration
- `COUNTDOWN_ALARM_EN` defined:
  - `alarm` rises with `done`.
  - It stays high for ALARM_TICKS `tick` pulses, counted in DONE, then falls.
  - `stop` or `load` clears it at once.
  - The tick counter is 8 bits wide and saturates.
- Not defined: `alarm` is tied 0 and no alarm counter is built. The port remains.

## Test plan
- Reset low mid-RUN at 01:02:03 → immediately 00:00:00, state=0, `done`=0, `zero`=1.
- Load 00:01:00, start, 1 tick → 00:00:59. 59 more ticks → 00:00:00, `done` one cycle, state=3.
- Load 02:00:00, start, 1 tick → 01:59:59 (double borrow). Load sec_in=75, hr_in=30 → 23:59:59 after saturation.
- RUN, stop → PAUSE; 5 ticks → count unchanged. Start → resumes. Start+stop same cycle → stop wins.
- Load 00:00:00, start → stays IDLE, no `done`. Tick coincident with load → new preset loaded, no decrement.
- With `COUNTDOWN_ALARM_EN`, ALARM_TICKS=3: expiry → `alarm` high for exactly 3 ticks. Stop during alarm → `alarm`=0 next edge. Without the macro → `alarm` always 0.
